// File: rtl/riscv_multicycle_controller_if.sv
// Control bus between the multi-cycle controller and its RV32I datapath.
// The master side is the controller; the slave side is the datapath.
interface riscv_multicycle_controller_if #(
  parameter int AluCtrlBits = 4
);
  logic [6:0]             op_i;
  logic [2:0]             funct3_i;
  logic                   funct7b5_i;
  logic [3:0]             onzc_i;
  logic                   mem_ready_i;
  logic                   pc_write_o;
  logic                   ir_write_o;
  logic                   adr_source_o;
  logic                   memory_write_o;
  logic                   reg_write_o;
  logic [1:0]             alu_source_a_o;
  logic [1:0]             alu_source_b_o;
  logic [2:0]             immediate_source_o;
  logic [AluCtrlBits-1:0] alu_control_o;
  logic [1:0]             result_source_o;
  logic [2:0]             result_extend_control_o;
  logic                   illegal_o;
  logic [3:0]             state_o;

  modport master (
    input  op_i, funct3_i, funct7b5_i, onzc_i, mem_ready_i,
    output pc_write_o, ir_write_o, adr_source_o, memory_write_o, reg_write_o,
           alu_source_a_o, alu_source_b_o, immediate_source_o, alu_control_o,
           result_source_o, result_extend_control_o, illegal_o, state_o
  );

  modport slave (
    output op_i, funct3_i, funct7b5_i, onzc_i, mem_ready_i,
    input  pc_write_o, ir_write_o, adr_source_o, memory_write_o, reg_write_o,
           alu_source_a_o, alu_source_b_o, immediate_source_o, alu_control_o,
           result_source_o, result_extend_control_o, illegal_o, state_o
  );
endinterface

// File: rtl/riscv_multicycle_controller.sv
// Moore FSM sequencing a shared-ALU, single-memory-port multi-cycle RV32I datapath.
// Outputs are forced to zero while rst_i is high so no enable leaks during reset.
module riscv_multicycle_controller #(
  parameter bit TrapOnIllegal = 1'b1,
  parameter int AluCtrlBits   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  riscv_multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECUTER = 4'd6, S_EXECUTEI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
    S_JALLINK = 4'd12, S_LUI = 4'd13, S_AUIPC = 4'd14, S_TRAP = 4'd15
  } state_t;

  localparam logic [AluCtrlBits-1:0] ALU_ADD  = AluCtrlBits'(0);
  localparam logic [AluCtrlBits-1:0] ALU_SUB  = AluCtrlBits'(1);
  localparam logic [AluCtrlBits-1:0] ALU_AND  = AluCtrlBits'(2);
  localparam logic [AluCtrlBits-1:0] ALU_OR   = AluCtrlBits'(3);
  localparam logic [AluCtrlBits-1:0] ALU_XOR  = AluCtrlBits'(4);
  localparam logic [AluCtrlBits-1:0] ALU_SLT  = AluCtrlBits'(5);
  localparam logic [AluCtrlBits-1:0] ALU_SLTU = AluCtrlBits'(6);
  localparam logic [AluCtrlBits-1:0] ALU_SLL  = AluCtrlBits'(7);
  localparam logic [AluCtrlBits-1:0] ALU_SRL  = AluCtrlBits'(8);
  localparam logic [AluCtrlBits-1:0] ALU_SRA  = AluCtrlBits'(9);
  localparam logic [AluCtrlBits-1:0] ALU_PASSB = AluCtrlBits'(10);

  state_t                 r_state, w_next;
  logic                   r_illegal;
  logic                   w_illegal_op;
  logic                   w_taken;
  logic                   w_pc_write, w_ir_write, w_adr_source, w_memory_write, w_reg_write;
  logic [1:0]             w_src_a, w_src_b, w_result_source;
  logic [2:0]             w_imm_source, w_extend;
  logic [AluCtrlBits-1:0] w_alu_control;

  // funct7b5 selects sub only for R-type; it always selects sra for shifts.
  function automatic logic [AluCtrlBits-1:0] alu_decode(input logic [2:0] f3,
                                                        input logic f7b5,
                                                        input logic is_r);
    case (f3)
      3'b000:  alu_decode = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (bus.op_i)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: w_illegal_op = 1'b0;
      default:                                         w_illegal_op = 1'b1;
    endcase
  end

  // onzc_i = {V, N, Z, C}
  always_comb begin
    case (bus.funct3_i)
      3'b000:  w_taken = bus.onzc_i[1];
      3'b001:  w_taken = !bus.onzc_i[1];
      3'b100:  w_taken = bus.onzc_i[2] ^ bus.onzc_i[3];
      3'b101:  w_taken = !(bus.onzc_i[2] ^ bus.onzc_i[3]);
      3'b110:  w_taken = !bus.onzc_i[0];
      3'b111:  w_taken = bus.onzc_i[0];
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_illegal_op) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_ir_write      = 1'b0;
    w_adr_source    = 1'b0;
    w_memory_write  = 1'b0;
    w_reg_write     = 1'b0;
    w_src_a         = 2'b00;
    w_src_b         = 2'b00;
    w_imm_source    = 3'b000;
    w_alu_control   = ALU_ADD;
    w_result_source = 2'b00;
    w_extend        = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_src_b         = 2'b10;
        w_result_source = 2'b10;
        w_pc_write      = bus.mem_ready_i;
        w_ir_write      = bus.mem_ready_i;
        if (bus.mem_ready_i) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_src_a      = 2'b01;
        w_src_b      = 2'b01;
        w_imm_source = (bus.op_i == 7'b1101111) ? 3'b011 : 3'b010;
        case (bus.op_i)
          7'b0000011, 7'b0100011: w_next = S_MEMADR;
          7'b0110011:             w_next = S_EXECUTER;
          7'b0010011:             w_next = S_EXECUTEI;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          7'b1100111:             w_next = S_JALR;
          7'b0110111:             w_next = S_LUI;
          7'b0010111:             w_next = S_AUIPC;
          default:                w_next = TrapOnIllegal ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b01;
        w_imm_source = bus.op_i[5] ? 3'b001 : 3'b000;
        w_next       = bus.op_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_source = 1'b1;
        if (bus.mem_ready_i) w_next = S_MEMWB;
      end
      S_MEMWRITE: begin
        w_adr_source   = 1'b1;
        w_memory_write = 1'b1;
        if (bus.mem_ready_i) w_next = S_FETCH;
      end
      S_MEMWB: begin
        w_result_source = 2'b01;
        w_reg_write     = 1'b1;
        w_extend        = bus.funct3_i;
        w_next          = S_FETCH;
      end
      S_EXECUTER: begin
        w_src_a       = 2'b10;
        w_alu_control = alu_decode(bus.funct3_i, bus.funct7b5_i, 1'b1);
        w_next        = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_src_a       = 2'b10;
        w_src_b       = 2'b01;
        w_alu_control = alu_decode(bus.funct3_i, bus.funct7b5_i, 1'b0);
        w_next        = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a       = 2'b10;
        w_alu_control = ALU_SUB;
        w_pc_write    = w_taken;
        w_next        = S_FETCH;
      end
      S_JAL: begin
        w_pc_write = 1'b1;
        w_src_a    = 2'b01;
        w_src_b    = 2'b10;
        w_next     = S_ALUWB;
      end
      S_JALR: begin
        w_src_a         = 2'b10;
        w_src_b         = 2'b01;
        w_result_source = 2'b10;
        w_pc_write      = 1'b1;
        w_next          = S_JALLINK;
      end
      S_JALLINK: begin
        w_src_a = 2'b01;
        w_src_b = 2'b10;
        w_next  = S_ALUWB;
      end
      S_LUI: begin
        w_src_b       = 2'b01;
        w_imm_source  = 3'b100;
        w_alu_control = ALU_PASSB;
        w_next        = S_ALUWB;
      end
      S_AUIPC: begin
        w_src_a      = 2'b01;
        w_src_b      = 2'b01;
        w_imm_source = 3'b100;
        w_next       = S_ALUWB;
      end
      default: w_next = S_TRAP;
    endcase
  end

  assign bus.pc_write_o              = !rst_i && w_pc_write;
  assign bus.ir_write_o              = !rst_i && w_ir_write;
  assign bus.adr_source_o            = !rst_i && w_adr_source;
  assign bus.memory_write_o          = !rst_i && w_memory_write;
  assign bus.reg_write_o             = !rst_i && w_reg_write;
  assign bus.alu_source_a_o          = rst_i ? 2'b00 : w_src_a;
  assign bus.alu_source_b_o          = rst_i ? 2'b00 : w_src_b;
  assign bus.immediate_source_o      = rst_i ? 3'b000 : w_imm_source;
  assign bus.alu_control_o           = rst_i ? ALU_ADD : w_alu_control;
  assign bus.result_source_o         = rst_i ? 2'b00 : w_result_source;
  assign bus.result_extend_control_o = rst_i ? 3'b000 : w_extend;
  assign bus.illegal_o               = !rst_i && r_illegal;
  assign bus.state_o                 = rst_i ? 4'd0 : r_state;
endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Directed bench for riscv_multicycle_controller: per-cycle expected outputs
// go through a scoreboard queue and are checked against the DUT each cycle.
module tb_riscv_multicycle_controller;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;

  riscv_multicycle_controller_if #(.AluCtrlBits(4)) bus ();

  riscv_multicycle_controller #(.TrapOnIllegal(1'b1), .AluCtrlBits(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st, pcw, irw, memw, regw, ill, alu, rs, ext, sel;
  } exp_t;
  exp_t sb[$];

  // sel = {adr_source, alu_source_a, alu_source_b, immediate_source}
  localparam int SEL_0   = 8'b0_00_00_000;
  localparam int SEL_F   = 8'b0_00_10_000;
  localparam int SEL_DB  = 8'b0_01_01_010;
  localparam int SEL_DJ  = 8'b0_01_01_011;
  localparam int SEL_AI  = 8'b0_10_01_000;
  localparam int SEL_AS  = 8'b0_10_01_001;
  localparam int SEL_MEM = 8'b1_00_00_000;
  localparam int SEL_RR  = 8'b0_10_00_000;
  localparam int SEL_PC4 = 8'b0_01_10_000;
  localparam int SEL_LUI = 8'b0_00_01_100;
  localparam int SEL_AUI = 8'b0_01_01_100;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, obs, exp);
    end
  endtask

  task automatic step(input int st, input int pcw, input int irw, input int memw,
                      input int regw, input int ill, input int alu, input int rs,
                      input int ext, input int sel);
    exp_t e;
    e = '{st, pcw, irw, memw, regw, ill, alu, rs, ext, sel};
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("state",   32'(bus.state_o), e.st);
    chk("pc_write", 32'(bus.pc_write_o), e.pcw);
    chk("ir_write", 32'(bus.ir_write_o), e.irw);
    chk("mem_write", 32'(bus.memory_write_o), e.memw);
    chk("reg_write", 32'(bus.reg_write_o), e.regw);
    chk("illegal", 32'(bus.illegal_o), e.ill);
    chk("alu_ctrl", 32'(bus.alu_control_o), e.alu);
    chk("result_src", 32'(bus.result_source_o), e.rs);
    chk("extend", 32'(bus.result_extend_control_o), e.ext);
    chk("selects", 32'({bus.adr_source_o, bus.alu_source_a_o, bus.alu_source_b_o,
                        bus.immediate_source_o}), e.sel);
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic s_fetch();       step(0, 1, 1, 0, 0, 0, 0, 2, 0, SEL_F);  endtask
  task automatic s_fetch_stall(); step(0, 0, 0, 0, 0, 0, 0, 2, 0, SEL_F);  endtask
  task automatic s_decode();      step(1, 0, 0, 0, 0, 0, 0, 0, 0, SEL_DB); endtask
  task automatic s_aluwb();       step(8, 0, 0, 0, 1, 0, 0, 0, 0, SEL_0);  endtask
  task automatic s_reset();       step(0, 0, 0, 0, 0, 0, 0, 0, 0, SEL_0);  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op_i       = op;
    bus.funct3_i   = f3;
    bus.funct7b5_i = f7;
  endtask

  initial begin
    rst             = 1'b1;
    bus.op_i        = 7'd0;
    bus.funct3_i    = 3'd0;
    bus.funct7b5_i  = 1'b0;
    bus.onzc_i      = 4'd0;
    bus.mem_ready_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    s_reset();
    rst = 1'b0;

    // lw
    set_instr(7'b0000011, 3'b010, 1'b0);
    s_fetch();
    s_decode();
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, SEL_AI);
    step(3, 0, 0, 0, 0, 0, 0, 0, 0, SEL_MEM);
    step(4, 0, 0, 0, 1, 0, 0, 1, 2, SEL_0);

    // add, sub
    set_instr(7'b0110011, 3'b000, 1'b0);
    s_fetch(); s_decode();
    step(6, 0, 0, 0, 0, 0, 0, 0, 0, SEL_RR);
    s_aluwb();
    set_instr(7'b0110011, 3'b000, 1'b1);
    s_fetch(); s_decode();
    step(6, 0, 0, 0, 0, 0, 1, 0, 0, SEL_RR);
    s_aluwb();

    // beq taken / not taken, bltu taken, bge not taken (N=0, V=1)
    set_instr(7'b1100011, 3'b000, 1'b0);
    bus.onzc_i = 4'b0010;
    s_fetch(); s_decode();
    step(9, 1, 0, 0, 0, 0, 1, 0, 0, SEL_RR);
    bus.onzc_i = 4'b0000;
    s_fetch(); s_decode();
    step(9, 0, 0, 0, 0, 0, 1, 0, 0, SEL_RR);
    set_instr(7'b1100011, 3'b110, 1'b0);
    s_fetch(); s_decode();
    step(9, 1, 0, 0, 0, 0, 1, 0, 0, SEL_RR);
    set_instr(7'b1100011, 3'b101, 1'b0);
    bus.onzc_i = 4'b1000;
    s_fetch(); s_decode();
    step(9, 0, 0, 0, 0, 0, 1, 0, 0, SEL_RR);

    // sw with three wait cycles
    set_instr(7'b0100011, 3'b010, 1'b0);
    s_fetch(); s_decode();
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, SEL_AS);
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step(5, 0, 0, 1, 0, 0, 0, 0, 0, SEL_MEM);
    bus.mem_ready_i = 1'b1;
    step(5, 0, 0, 1, 0, 0, 0, 0, 0, SEL_MEM);

    // srai after a two-cycle fetch stall
    set_instr(7'b0010011, 3'b101, 1'b1);
    bus.mem_ready_i = 1'b0;
    s_fetch_stall(); s_fetch_stall();
    bus.mem_ready_i = 1'b1;
    s_fetch(); s_decode();
    step(7, 0, 0, 0, 0, 0, 9, 0, 0, SEL_AI);
    s_aluwb();

    // addi with funct7b5 set is still add
    set_instr(7'b0010011, 3'b000, 1'b1);
    s_fetch(); s_decode();
    step(7, 0, 0, 0, 0, 0, 0, 0, 0, SEL_AI);
    s_aluwb();

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    s_fetch();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, SEL_DJ);
    step(10, 1, 0, 0, 0, 0, 0, 0, 0, SEL_PC4);
    s_aluwb();

    // jalr
    set_instr(7'b1100111, 3'b000, 1'b0);
    s_fetch(); s_decode();
    step(11, 1, 0, 0, 0, 0, 0, 2, 0, SEL_AI);
    step(12, 0, 0, 0, 0, 0, 0, 0, 0, SEL_PC4);
    s_aluwb();

    // lui, auipc
    set_instr(7'b0110111, 3'b000, 1'b0);
    s_fetch(); s_decode();
    step(13, 0, 0, 0, 0, 0, 10, 0, 0, SEL_LUI);
    s_aluwb();
    set_instr(7'b0010111, 3'b000, 1'b0);
    s_fetch(); s_decode();
    step(14, 0, 0, 0, 0, 0, 0, 0, 0, SEL_AUI);
    s_aluwb();

    // reset during a stalled load
    set_instr(7'b0000011, 3'b100, 1'b0);
    s_fetch(); s_decode();
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, SEL_AI);
    bus.mem_ready_i = 1'b0;
    step(3, 0, 0, 0, 0, 0, 0, 0, 0, SEL_MEM);
    rst = 1'b1;
    s_reset();
    rst = 1'b0;
    bus.mem_ready_i = 1'b1;
    s_fetch(); s_decode();
    step(2, 0, 0, 0, 0, 0, 0, 0, 0, SEL_AI);
    step(3, 0, 0, 0, 0, 0, 0, 0, 0, SEL_MEM);
    step(4, 0, 0, 0, 1, 0, 0, 1, 4, SEL_0);

    // illegal opcode -> sticky TRAP, cleared only by reset
    set_instr(7'b1111111, 3'b000, 1'b0);
    s_fetch(); s_decode();
    for (int i = 0; i < 10; i++) step(15, 0, 0, 0, 0, 1, 0, 0, 0, SEL_0);
    rst = 1'b1;
    s_reset();
    rst = 1'b0;
    s_fetch();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Moore-style FSM that sequences a shared-ALU, single-memory-port multi-cycle RV32I datapath. This is the multi-cycle successor to the existing single-cycle core.
- Decodes opcode, funct3 and funct7b5 from the latched instruction register. Drives all mux selects, write enables and ALU control, one step per cycle.
- Handles wait states via a memory-ready handshake. Flags illegal opcodes.

Parameters:
- TrapOnIllegal, 1, 1 = illegal opcode enters sticky TRAP; 0 = treated as NOP (DECODE returns to FETCH).
- AluCtrlBits, 4, width of alu_control_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- op_i  in  7  instruction[6:0] from instruction register
- funct3_i  in  3  instruction[14:12]
- funct7b5_i  in  1  instruction[30]
- onzc_i  in  4  ALU flags: [3]=overflow, [2]=negative, [1]=zero, [0]=carry (carry=1 means a>=b unsigned on subtract)
- mem_ready_i  in  1  memory access completes this cycle
- pc_write_o  out  1  PC register load enable
- ir_write_o  out  1  instruction/old-PC register load enable
- adr_source_o  out  1  memory address: 0=PC, 1=result
- memory_write_o  out  1  data memory write request
- reg_write_o  out  1  register file write enable
- alu_source_a_o  out  2  00=PC, 01=old PC, 10=register A
- alu_source_b_o  out  2  00=register B, 01=immediate, 10=constant 4
- immediate_source_o  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- alu_control_o  out  AluCtrlBits  0=add, 1=sub, 2=and, 3=or, 4=xor, 5=slt, 6=sltu, 7=sll, 8=srl, 9=sra, 10=pass-B
- result_source_o  out  2  00=ALU-out register, 01=extended read data, 10=ALU result direct
- result_extend_control_o  out  3  funct3 passthrough in MEMWB, else 000
- illegal_o  out  1  sticky illegal-instruction flag
- state_o  out  4  current state encoding (debug)

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALLINK 12, LUI 13, AUIPC 14, TRAP 15.
- Reset behaviour:
  - While rst_i=1 on a clock edge: state<=FETCH, illegal_o<=0.
  - Outputs during reset cycles: all enables 0 (pc_write, ir_write, memory_write, reg_write), all selects 0, state_o=0.
  - Reset overrides any state, including a stalled memory access or TRAP.
- Unlisted outputs default to 0 in every state.
- FETCH:
  - adr=0, a=PC, b=4, add, result_source=10.
  - ir_write and pc_write are asserted only when mem_ready_i=1.
  - Hold FETCH while mem_ready_i=0; go to DECODE when mem_ready_i=1.
- DECODE:
  - a=old PC, b=imm, add; imm=J if op=1101111, else B. This latches the branch/jump target in the ALU-out register.
  - Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other op -> TRAP (or FETCH when TrapOnIllegal=0)
- MEMADR: a=A, b=imm, add; imm=I for load, S for store. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: adr=1, result_source=00. Hold until mem_ready_i, then go to MEMWB.
- MEMWRITE: adr=1, result_source=00, memory_write=1 held every cycle until mem_ready_i, then go to FETCH.
- MEMWB: result_source=01, reg_write=1, extend=funct3_i. Next: FETCH.
- EXECUTER: a=A, b=B.
  - ALU op from funct3: 000 add, or sub if funct7b5=1; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra if funct7b5=1; 110 or; 111 and.
  - Next: ALUWB.
- EXECUTEI: a=A, b=imm(I).
  - Same ALU decode as EXECUTER, except funct3=000 is always add.
  - funct7b5 distinguishes srai only.
  - Next: ALUWB.
- ALUWB: result_source=00, reg_write=1. Next: FETCH.
- BRANCH: a=A, b=B, sub, result_source=00.
  - pc_write=taken, where taken by funct3: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C.
  - funct3 010/011 -> not taken.
  - Next: FETCH.
- JAL: result_source=00, pc_write=1; a=old PC, b=4, add. Next: ALUWB (writes link address).
- JALR: a=A, b=imm(I), add, result_source=10, pc_write=1. Next: JALLINK. The datapath clears bit 0 of the target.
- JALLINK: a=old PC, b=4, add. Next: ALUWB.
- LUI: b=imm(U), pass-B. Next: ALUWB.
- AUIPC: a=old PC, b=imm(U), add. Next: ALUWB.
- TRAP: illegal_o=1, all enables 0. Stays in TRAP until reset.
- Latency with mem_ready_i always 1:
  - load 5 cycles; store 4; R/I-type 4; branch 3; jal 4; jalr 5; lui/auipc 4.
  - Each low cycle of mem_ready_i adds one cycle in FETCH, MEMREAD or MEMWRITE.

Test Plan:
- Reset, then lw (op 0000011, funct3 010), ready=1 -> state_o 0,1,2,3,4,0; reg_write=1 only in state 4; result_extend_control_o=010 in MEMWB.
- add then sub R-type -> EXECUTER alu_control_o=0, then 1 on the sub; reg_write pulses once per instruction; 4 cycles each.
- beq with onzc=0010, then onzc=0000 -> pc_write=1 in BRANCH for the first, 0 for the second. bltu with onzc=0000 -> taken.
- sw with mem_ready_i low for 3 cycles in MEMWRITE -> memory_write=1 held 4 cycles; FETCH reached on the cycle after ready. Fetch stall: pc_write/ir_write stay 0 until ready.
- op=1111111 -> TRAP(15), illegal_o=1, no enables for 10 cycles. rst_i=1 -> state FETCH, illegal_o=0 next cycle.
- Assert rst_i while in MEMREAD with ready=0 -> FETCH next edge, no reg_write issued. jal -> 10, 8, 0 with pc_write=1 in 10.
